// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan receiver: glyph masks, widths,
// FSM states and the anode-select decoder.
package seg_scan_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int CODE_W = 4;

  // Lit-segment masks (active-high), bit 0 = a ... bit 6 = g
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    SYNC_WAIT,
    CAPTURE,
    PUBLISH
  } scan_state_t;

  // Returns {valid, index}; only a single low anode bit selects a digit
  function automatic logic [2:0] anode_select(input logic [DIGITS-1:0] anode);
    logic [2:0] result;
    case (anode)
      4'b1110: result = 3'b100;
      4'b1101: result = 3'b101;
      4'b1011: result = 3'b110;
      4'b0111: result = 3'b111;
      default: result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of an active-low seven-segment pattern into a hex code
// plus a flag saying whether the pattern was a recognised glyph.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0]  pattern,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  logic [SEG_W-1:0] lit;

  assign lit = ~pattern;

  always_comb begin
    valid = 1'b1;
    code  = 4'h0;
    case (lit)
      GLYPH_0: code = 4'h0;
      GLYPH_1: code = 4'h1;
      GLYPH_2: code = 4'h2;
      GLYPH_3: code = 4'h3;
      GLYPH_4: code = 4'h4;
      GLYPH_5: code = 4'h5;
      GLYPH_6: code = 4'h6;
      GLYPH_7: code = 4'h7;
      GLYPH_8: code = 4'h8;
      GLYPH_9: code = 4'h9;
      GLYPH_A: code = 4'hA;
      GLYPH_B: code = 4'hB;
      GLYPH_C: code = 4'hC;
      GLYPH_D: code = 4'hD;
      GLYPH_E: code = 4'hE;
      GLYPH_F: code = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receives a multiplexed 4-digit seven-segment bus, qualifies digits by
// stability and publishes complete frames. Define SEG_SCAN_RAW_EN for raw output.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                     clk_100MHz,
  input  logic                     rst,
  input  logic [SEG_W-1:0]         segments_in,
  input  logic [DIGITS-1:0]        anode_in,
  output logic [CODE_W*DIGITS-1:0] digit_code,
  output logic [DIGITS-1:0]        digit_valid,
  output logic                     frame_valid,
  output logic                     link_lost
`ifdef SEG_SCAN_RAW_EN
  ,
  output logic [SEG_W*DIGITS-1:0]  seg_raw_flat
`endif
);

  localparam int BUS_W = DIGITS + SEG_W;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [BUS_W-1:0]         bus_meta, bus_sync, bus_prev;
  logic [DIGITS-1:0]        anode_s;
  logic [SEG_W-1:0]         seg_s;
  logic [2:0]               sel;
  logic                     sel_valid;
  logic [1:0]               sel_idx;
  logic [7:0]               stab_cnt, stab_run;
  logic                     accept;
  logic                     glyph_valid;
  logic [CODE_W-1:0]        glyph_code;
  logic [TW-1:0]            tcnt, tcnt_next;
  logic [DIGITS-1:0]        mask, mask_next, accept_bit;
  logic [CODE_W*DIGITS-1:0] shadow_code, code_next;
  logic [DIGITS-1:0]        shadow_valid, valid_next;
  logic                     publish_load;
  scan_state_t              state, state_next;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      bus_meta <= '1;
      bus_sync <= '1;
      bus_prev <= '1;
    end else begin
      bus_meta <= {anode_in, segments_in};
      bus_sync <= bus_meta;
      bus_prev <= bus_sync;
    end
  end

  assign anode_s   = bus_sync[BUS_W-1:SEG_W];
  assign seg_s     = bus_sync[SEG_W-1:0];
  assign sel       = anode_select(anode_s);
  assign sel_valid = sel[2];
  assign sel_idx   = sel[1:0];

  // Run length of the current sample; saturation makes a held digit accept once
  always_comb begin
    stab_run = '0;
    if (sel_valid) begin
      if (bus_sync != bus_prev)
        stab_run = 8'd1;
      else if (stab_cnt == STABLE_MAX)
        stab_run = STABLE_MAX;
      else
        stab_run = stab_cnt + 8'd1;
    end
  end

  assign accept     = sel_valid && (stab_run == STABLE_MAX) && (stab_cnt != STABLE_MAX);
  assign accept_bit = accept ? (DIGITS'(1) << sel_idx) : '0;

  seg_glyph_decode u_decode (
    .pattern (seg_s),
    .valid   (glyph_valid),
    .code    (glyph_code)
  );

  always_comb begin
    code_next  = shadow_code;
    valid_next = shadow_valid;
    if (accept) begin
      code_next[int'(sel_idx)*CODE_W +: CODE_W] = glyph_code;
      valid_next[sel_idx]                       = glyph_valid;
    end
  end

  always_comb begin
    tcnt_next = tcnt;
    if (accept)
      tcnt_next = '0;
    else if (tcnt != TIMEOUT_MAX)
      tcnt_next = tcnt + TW'(1);
  end

  always_comb begin
    state_next = state;
    mask_next  = mask;
    case (state)
      SYNC_WAIT: begin
        mask_next = accept_bit;
        if (accept)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        mask_next = mask | accept_bit;
        if (mask_next == '1) begin
          state_next = PUBLISH;
        end else if (tcnt_next == TIMEOUT_MAX) begin
          state_next = SYNC_WAIT;
          mask_next  = '0;
        end
      end
      PUBLISH: begin
        mask_next  = accept_bit;
        state_next = CAPTURE;
      end
      default: begin
        state_next = SYNC_WAIT;
        mask_next  = '0;
      end
    endcase
  end

  // Outputs load on the edge entering PUBLISH so they appear with frame_valid
  assign publish_load = (state == CAPTURE) && (state_next == PUBLISH);

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state        <= SYNC_WAIT;
      stab_cnt     <= '0;
      tcnt         <= '0;
      mask         <= '0;
      shadow_code  <= '0;
      shadow_valid <= '0;
      digit_code   <= '0;
      digit_valid  <= '0;
    end else begin
      state        <= state_next;
      stab_cnt     <= stab_run;
      tcnt         <= tcnt_next;
      mask         <= mask_next;
      shadow_code  <= code_next;
      shadow_valid <= valid_next;
      if (publish_load) begin
        digit_code  <= code_next;
        digit_valid <= valid_next;
      end
    end
  end

`ifdef SEG_SCAN_RAW_EN
  logic [SEG_W*DIGITS-1:0] shadow_raw, raw_next;

  always_comb begin
    raw_next = shadow_raw;
    if (accept)
      raw_next[int'(sel_idx)*SEG_W +: SEG_W] = seg_s;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      shadow_raw   <= '0;
      seg_raw_flat <= '1;
    end else begin
      shadow_raw <= raw_next;
      if (publish_load)
        seg_raw_flat <= raw_next;
    end
  end
`endif

  assign frame_valid = (state == PUBLISH);
  assign link_lost   = (state == SYNC_WAIT);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed digit sequences push expected
// frames into a queue that a frame_valid monitor pops and compares.
module tb_seg_scan_decoder;

  typedef struct packed {
    logic [15:0] code;
    logic [3:0]  valid;
  } frame_t;

  // Active-low segment patterns for the glyphs used here
  localparam logic [6:0] S1    = 7'h79;
  localparam logic [6:0] S2    = 7'h24;
  localparam logic [6:0] S3    = 7'h30;
  localparam logic [6:0] S4    = 7'h19;
  localparam logic [6:0] S5    = 7'h12;
  localparam logic [6:0] S6    = 7'h02;
  localparam logic [6:0] S7    = 7'h78;
  localparam logic [6:0] S9    = 7'h10;
  localparam logic [6:0] SOFF  = 7'h7F;
  localparam logic [3:0] AN0   = 4'hE;
  localparam logic [3:0] AN1   = 4'hD;
  localparam logic [3:0] AN2   = 4'hB;
  localparam logic [3:0] AN3   = 4'h7;
  localparam logic [3:0] BLANK = 4'hF;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segments_in = SOFF;
  logic [3:0]  anode_in = BLANK;
  logic [15:0] digit_code;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        link_lost;
`ifdef SEG_SCAN_RAW_EN
  logic [27:0] seg_raw_flat;
`endif

  int     n_compared = 0;
  int     n_mismatched = 0;
  int     frame_cnt = 0;
  frame_t expected_q[$];

  seg_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .segments_in (segments_in),
    .anode_in    (anode_in),
    .digit_code  (digit_code),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .link_lost   (link_lost)
`ifdef SEG_SCAN_RAW_EN
    ,
    .seg_raw_flat (seg_raw_flat)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic send_digit(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    anode_in    = an;
    segments_in = seg;
    repeat (cycles) @(negedge clk_100MHz);
  endtask

  task automatic expect_frame(input logic [15:0] code, input logic [3:0] valid);
    frame_t f;
    f.code  = code;
    f.valid = valid;
    expected_q.push_back(f);
  endtask

  // Monitor: every published frame must match the oldest expected entry
  always @(negedge clk_100MHz) begin
    if (frame_valid === 1'b1) begin
      frame_cnt++;
      if (expected_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_frame: got code %0h valid %0h, required no frame",
                 digit_code, digit_valid);
      end else begin
        frame_t f;
        f = expected_q.pop_front();
        check("frame_code", 32'(digit_code), 32'(f.code));
        check("frame_valid_mask", 32'(digit_valid), 32'(f.valid));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int frames_before;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    check("reset_link_lost", 32'(link_lost), 32'd1);
    check("reset_digit_code", 32'(digit_code), 32'd0);
    check("reset_digit_valid", 32'(digit_valid), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_100MHz);
    check("idle_link_lost", 32'(link_lost), 32'd1);

    // Nominal frame 4321
    expect_frame(16'h4321, 4'hF);
    send_digit(AN0, S1, 20);
    send_digit(AN1, S2, 20);
    send_digit(AN2, S3, 20);
    send_digit(AN3, S4, 20);
    check("nominal_link_lost", 32'(link_lost), 32'd0);
    check("nominal_frame_count", 32'(frame_cnt), 32'd1);

    // Short glitch on digit 0 and a long blank must not be captured
    send_digit(AN0, S9, 3);
    send_digit(BLANK, SOFF, 50);
    frames_before = frame_cnt;
    send_digit(AN1, S5, 20);
    send_digit(AN2, S5, 20);
    send_digit(AN3, S5, 20);
    check("glitch_no_frame", 32'(frame_cnt), 32'(frames_before));
    expect_frame(16'h5556, 4'hF);
    send_digit(AN0, S6, 20);

    // Unrecognised pattern on digit 2
    expect_frame(16'h5055, 4'hB);
    send_digit(AN0, S5, 20);
    send_digit(AN1, S5, 20);
    send_digit(AN2, SOFF, 20);
    send_digit(AN3, S5, 20);

    // Digit 0 overwritten 7 -> 9 before the frame completes
    expect_frame(16'h3219, 4'hF);
    send_digit(AN0, S7, 20);
    send_digit(AN0, S9, 20);
    send_digit(AN1, S1, 20);
    send_digit(AN2, S2, 20);

    // Last digit then hold: accept lands on the 6th edge, timeout 1000 edges later
    anode_in    = AN3;
    segments_in = S3;
    repeat (1005) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("timeout_before", 32'(link_lost), 32'd0);
    @(negedge clk_100MHz);
    check("timeout_at", 32'(link_lost), 32'd1);
    check("timeout_hold_code", 32'(digit_code), 32'h3219);
    check("timeout_hold_valid", 32'(digit_valid), 32'hF);

    // Resumed traffic clears link_lost on its first accept
    anode_in    = AN0;
    segments_in = S6;
    repeat (5) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("resume_before_accept", 32'(link_lost), 32'd1);
    @(negedge clk_100MHz);
    check("resume_after_accept", 32'(link_lost), 32'd0);
    repeat (14) @(negedge clk_100MHz);
    send_digit(AN1, S1, 20);

    // Reset after two accepts discards the partial frame
    rst         = 1'b1;
    anode_in    = BLANK;
    segments_in = SOFF;
    repeat (2) @(negedge clk_100MHz);
    check("midreset_digit_code", 32'(digit_code), 32'd0);
    check("midreset_digit_valid", 32'(digit_valid), 32'd0);
    check("midreset_link_lost", 32'(link_lost), 32'd1);
    rst = 1'b0;
    frames_before = frame_cnt;
    send_digit(AN2, S2, 20);
    send_digit(AN3, S3, 20);
    check("midreset_no_frame", 32'(frame_cnt), 32'(frames_before));
    check("midreset_relink", 32'(link_lost), 32'd0);

    check("scoreboard_drained", 32'(expected_q.size()), 32'd0);
    check("total_frames", 32'(frame_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed seven-segment display path: samples a 4-digit time-multiplexed segment/anode bus, qualifies each digit by stability, decodes segment patterns back to hex codes and publishes a complete 4-digit frame. Used for board-to-board loopback checks and self-test of the display chain. Runs entirely in the 100 MHz domain; the bus inputs are asynchronous.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples (anode+segments) required to accept a digit; legal range 2..255.
- TIMEOUT_CYCLES, 500000: cycles without any accepted digit before link loss (5 ms at 100 MHz).

Ports:
- clk_100MHz  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- segments_in  in  7  segment bus, active-low; bit 0 = a … bit 6 = g.
- anode_in  in  4  digit select, active-low; bit 0 = rightmost digit.
- digit_code  out  16  published hex codes, digit i at [4i+3:4i].
- digit_valid  out  4  bit i = 1 when digit i pattern decoded to a legal hex glyph.
- frame_valid  out  1  one-cycle pulse when new frame published.
- link_lost  out  1  high while no digit accepted within TIMEOUT_CYCLES.
- seg_raw_flat  out  28  raw segment patterns, digit i at [7i+6:7i] (only with SEG_SCAN_RAW_EN).

## Operation
- Input sync: segments_in and anode_in each pass a 2-flop synchronizer before all logic.
- Select validity: anode with exactly one bit low is a valid select; 4'hF (blank) or more than one low is invalid and clears the stability counter.
- Stability: counter increments while synchronized {anode, segments} equals previous cycle's value and select is valid; any change reloads it to 1. Digit accepted on the cycle the counter reaches STABLE_CYCLES; counter saturates there so one activation yields exactly one accept.
- Decode: 7-bit pattern mapped to 0–F (standard glyphs, lowercase b/d); unlisted pattern gives code 0, valid 0.
- Accept writes shadow code/valid/raw for the selected digit and sets capture-mask bit; re-accept of an already captured digit overwrites the shadow.
- FSM states: SYNC_WAIT (reset state, link_lost=1), CAPTURE, PUBLISH.
  - SYNC_WAIT → CAPTURE on first accept (that accept is captured); link_lost clears same cycle.
  - CAPTURE → PUBLISH when mask becomes 4'hF.
  - PUBLISH (one cycle): shadow copied to outputs, frame_valid=1, mask cleared → CAPTURE. An accept in this cycle is captured into the new mask.
  - CAPTURE → SYNC_WAIT when timeout counter reaches TIMEOUT_CYCLES: mask cleared, link_lost=1; published outputs hold last frame.
- Timeout counter clears on every accept, saturates at TIMEOUT_CYCLES.

## Timing
- Reset values: digit_code 0, digit_valid 0, frame_valid 0, link_lost 1, seg_raw_flat all ones; mask, counters, shadows cleared; state SYNC_WAIT.
- Input change to accept: 2 sync cycles + STABLE_CYCLES−1 cycles.
- 4th accept in cycle N → frame_valid and new outputs visible in cycle N+1.
- Outputs change only in the PUBLISH cycle.
- rst mid-frame: all state returns to reset values next edge; partial frame discarded.

## Configuration
- SEG_SCAN_RAW_EN defined: seg_raw_flat port and raw shadow/output registers present, updated with the frame.
- Undefined: port and registers removed; all other behaviour identical.

## Structure
- Package seg_scan_pkg: 16 glyph pattern constants, FSM state enum, digit/segment width constants.
- Sub-module seg_glyph_decode: combinational 7-bit pattern → {valid, 4-bit code}.

## Test plan
- Reset: hold rst 3 cycles → link_lost=1, digit_code=0, digit_valid=0, frame_valid never pulses.
- Nominal frame: cycle anodes E,D,B,7 with glyphs 1,2,3,4, 20 cycles each → one frame_valid, digit_code=16'h4321, digit_valid=4'hF, link_lost=0.
- Glitch reject: present glyph for STABLE_CYCLES−1 cycles then change → no accept; blank anode 4'hF for 50 cycles → no mask change.
- Illegal pattern: digit 2 segments 7'h7F (all off) within a frame of 5s → digit_code=16'h5055, digit_valid=4'hB.
- Timeout: stop toggling after one frame, TIMEOUT_CYCLES=1000 → link_lost=1 exactly 1000 cycles after last accept; digit_code holds; resumed traffic clears link_lost on first accept.
- Overwrite and reset mid-frame: digit 0 accepted as 7 then 9 before frame completes → published code 9; assert rst after 2 accepts → no frame_valid, outputs at reset values.
